// File: rtl/lsu_bus_ctrl_pkg.sv
// Shared definitions for the load/store bus controller: opcodes, memory map
// tags, funct3 access encodings, FSM states and fault causes.
package lsu_bus_ctrl_pkg;

    typedef enum logic [6:0] {
        OP_L = 7'b0000011,
        OP_S = 7'b0100011
    } type_opcode;

    typedef enum logic [3:0] {
        MEM_DMEM = 4'h1,
        MEM_UART = 4'h2
    } type_mem_map;

    // Loads and stores share the size field; stores reuse the signed codes.
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } type_funct3_mem;

    localparam type_funct3_mem SB = LB;
    localparam type_funct3_mem SH = LH;
    localparam type_funct3_mem SW = LW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        NONE     = 2'b00,
        MISALIGN = 2'b01,
        UNMAPPED = 2'b10,
        TIMEOUT  = 2'b11
    } lsu_fault_t;

    // Loads allow 000/001/010/100/101; stores allow 000/001/010.
    function automatic logic funct3_illegal(input logic is_store, input logic [2:0] f3);
        if (is_store) return (f3 >= 3'b011);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Lane steering for the load/store unit: store byte enables and replicated
// write data, and load byte/half extraction with sign or zero extension.
module lsu_data_align
    import lsu_bus_ctrl_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wlane_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    // Size is funct3[1:0]; funct3[2] selects zero extension on loads.
    always_comb begin
        shifted = rword_i >> {offset_i, 3'b000};
        be_o    = 4'h0;
        wlane_o = wdata_i;
        rdata_o = shifted;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << offset_i;
                wlane_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{shifted[7] & ~funct3_i[2]}}, shifted[7:0]};
            end
            2'b01: begin
                be_o    = 4'b0011 << offset_i;
                wlane_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{shifted[15] & ~funct3_i[2]}}, shifted[15:0]};
            end
            2'b10: be_o = 4'hF;
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Memory-stage load/store bus controller. Decodes the address against
// NUM_REGIONS tagged slave regions, runs a strobe/ack handshake, stalls the
// pipeline until completion and reports load data or a fault.
// Optional feature: define LSU_TIMEOUT_EN to abort accesses that see no ack
// within TIMEOUT_CYCLES.
//   state  | meaning
//   IDLE   | waiting for a load/store; decode faults go straight to DONE
//   ACCESS | strobe asserted to the selected slave, waiting for its ack
//   DONE   | one-cycle completion: rdata_valid or fault pulse, stall low
module lsu_bus_ctrl
    import lsu_bus_ctrl_pkg::*;
#(
    parameter int                       DATA_WIDTH     = 32,
    parameter int                       NUM_REGIONS    = 2,
    parameter logic [NUM_REGIONS*4-1:0] REGION_TAGS    = {MEM_UART, MEM_DMEM},
    parameter int                       TIMEOUT_CYCLES = 255
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic [6:0]               opcode_in,
    input  logic [2:0]               funct3,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    output logic                     stall,
    output logic [31:0]              rdata,
    output logic                     rdata_valid,
    output logic                     fault,
    output logic [1:0]               fault_cause,
    output logic [NUM_REGIONS-1:0]   bus_sel,
    output logic                     bus_stb,
    output logic                     bus_we,
    output logic [3:0]               bus_be,
    output logic [31:0]              bus_addr,
    output logic [31:0]              bus_wdata,
    input  logic [NUM_REGIONS*32-1:0] bus_rdata,
    input  logic [NUM_REGIONS-1:0]   bus_ack
);

    if (DATA_WIDTH != 32 || NUM_REGIONS < 1 || NUM_REGIONS > 8 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
        $error("lsu_bus_ctrl: unsupported parameter set");
    end

    lsu_state_t             state_q;
    logic [NUM_REGIONS-1:0] sel_q;
    logic                   stb_q, we_q, rdata_valid_q, fault_q;
    logic [3:0]             be_q;
    logic [31:0]            addr_q, wdata_q, rdata_q;
    lsu_fault_t             cause_q;
    logic [2:0]             f3_q;
    logic [1:0]             off_q;
`ifdef LSU_TIMEOUT_EN
    logic [7:0]             tmo_q;
`endif

    logic                   is_mem, is_store, bad_access, hit, ack_hit;
    logic [NUM_REGIONS-1:0] sel_hit;
    logic [31:0]            sel_rword, al_wlane, al_rdata;
    logic [3:0]             al_be;
    logic [2:0]             al_f3;
    logic [1:0]             al_off;

    assign is_mem     = (opcode_in == OP_L) || (opcode_in == OP_S);
    assign is_store   = (opcode_in == OP_S);
    assign bad_access = funct3_illegal(is_store, funct3) ||
                        (funct3[1:0] == 2'b01 && addr[0]) ||
                        (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    assign stall      = (state_q == IDLE && req_valid && is_mem) || (state_q == ACCESS);
    assign ack_hit    = |(bus_ack & sel_q);

    // Store lanes come from the live request; load extraction from the latched one.
    assign al_f3  = (state_q == IDLE) ? funct3    : f3_q;
    assign al_off = (state_q == IDLE) ? addr[1:0] : off_q;

    // Region decode, lowest index wins on overlapping tags.
    always_comb begin
        sel_hit = '0;
        hit     = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (!hit && addr[31:28] == REGION_TAGS[4*i +: 4]) begin
                sel_hit[i] = 1'b1;
                hit        = 1'b1;
            end
        end
    end

    // Read data of the selected (one-hot) region.
    always_comb begin
        sel_rword = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (sel_q[i]) sel_rword |= bus_rdata[32*i +: 32];
        end
    end

    lsu_data_align u_align (
        .funct3_i (al_f3),
        .offset_i (al_off),
        .wdata_i  (wdata),
        .rword_i  (sel_rword),
        .be_o     (al_be),
        .wlane_o  (al_wlane),
        .rdata_o  (al_rdata)
    );

    // Sequencing FSM with registered bus and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            stb_q         <= 1'b0;
            we_q          <= 1'b0;
            be_q          <= 4'h0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            cause_q       <= NONE;
            f3_q          <= '0;
            off_q         <= '0;
`ifdef LSU_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            rdata_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && is_mem) begin
                        f3_q  <= funct3;
                        off_q <= addr[1:0];
                        if (bad_access) begin
                            fault_q <= 1'b1;
                            cause_q <= MISALIGN;
                            state_q <= DONE;
                        end else if (!hit) begin
                            fault_q <= 1'b1;
                            cause_q <= UNMAPPED;
                            state_q <= DONE;
                        end else begin
                            sel_q   <= sel_hit;
                            stb_q   <= 1'b1;
                            we_q    <= is_store;
                            be_q    <= al_be;
                            addr_q  <= {addr[31:2], 2'b00};
                            wdata_q <= is_store ? al_wlane : '0;
                            state_q <= ACCESS;
`ifdef LSU_TIMEOUT_EN
                            tmo_q   <= '0;
`endif
                        end
                    end
                end
                ACCESS: begin
                    if (ack_hit) begin
                        if (!we_q) begin
                            rdata_q       <= al_rdata;
                            rdata_valid_q <= 1'b1;
                        end
                        sel_q   <= '0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        be_q    <= 4'h0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        state_q <= DONE;
                    end
`ifdef LSU_TIMEOUT_EN
                    else begin
                        tmo_q <= tmo_q + 8'd1;
                        if (tmo_q + 8'd1 == 8'(TIMEOUT_CYCLES)) begin
                            fault_q <= 1'b1;
                            cause_q <= TIMEOUT;
                            sel_q   <= '0;
                            stb_q   <= 1'b0;
                            we_q    <= 1'b0;
                            be_q    <= 4'h0;
                            addr_q  <= '0;
                            wdata_q <= '0;
                            state_q <= DONE;
                        end
                    end
`endif
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_sel     = sel_q;
    assign bus_stb     = stb_q;
    assign bus_we      = we_q;
    assign bus_be      = be_q;
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: directed scenarios followed by random
// loads/stores, compared against a size/offset arithmetic reference model.
module tb_lsu_bus_ctrl;
    import lsu_bus_ctrl_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [6:0]  opcode_in = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall, rdata_valid, fault, bus_stb, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [1:0]  fault_cause, bus_sel;
    logic [3:0]  bus_be;
    logic [63:0] bus_rdata = '0;
    logic [1:0]  bus_ack = '0;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] exp_rdata = '0;
    logic [1:0]  exp_cause = '0;

    lsu_bus_ctrl #(.NUM_REGIONS(2), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .opcode_in(opcode_in),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
        .rdata(rdata), .rdata_valid(rdata_valid), .fault(fault),
        .fault_cause(fault_cause), .bus_sel(bus_sel), .bus_stb(bus_stb),
        .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: access size in bytes, legality, region lookup, lane math.
    function automatic void model(input logic is_st, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] rw, output logic [1:0] cause,
                                  output int region, output logic [3:0] be,
                                  output logic [31:0] lanes, output logic [31:0] ld);
        int size, off;
        logic [31:0] sh, mask;
        off = int'(a[1:0]);
        case (f3[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 0;
        endcase
        if (is_st && f3[2]) size = 0;
        if (!is_st && f3 == 3'b110) size = 0;
        region = -1;
        for (int i = 0; i < 2; i++)
            if (region < 0 && a[31:28] == ((i == 0) ? 4'h1 : 4'h2)) region = i;
        if (size == 0 || (off % size) != 0) cause = 2'b01;
        else if (region < 0)                 cause = 2'b10;
        else                                 cause = 2'b00;
        be    = 4'(((1 << size) - 1) << off);
        lanes = (size == 1) ? {4{wd[7:0]}} : (size == 2) ? {2{wd[15:0]}} : wd;
        sh    = rw >> (8 * off);
        ld    = sh;
        if (size == 1 || size == 2) begin
            mask = (32'h1 << (8 * size)) - 32'h1;
            ld   = sh & mask;
            if (!f3[2] && sh[8*size-1]) ld = ld | ~mask;
        end
    endfunction

    task automatic access(input logic is_st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rw,
                          input int waitn, input logic no_ack);
        logic [1:0]  cause, oh;
        int          reg_i;
        logic [3:0]  be;
        logic [31:0] lanes, ld;
        model(is_st, f3, a, wd, rw, cause, reg_i, be, lanes, ld);
        @(posedge clk); #1;
        req_valid = 1'b1;
        opcode_in = is_st ? OP_S : OP_L;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        bus_ack   = '0;
        bus_rdata = {$urandom, $urandom};
        if (reg_i >= 0) bus_rdata[32*reg_i +: 32] = rw;
        @(negedge clk);
        check("stall_req", stall, 1);
        check("stb_req", bus_stb, 0);
        if (cause != 2'b00) begin
            @(negedge clk);
            check("fault_dec", fault, 1);
            check("cause_dec", fault_cause, cause);
            check("stb_dec", bus_stb, 0);
            check("stall_dec", stall, 0);
            check("rvalid_dec", rdata_valid, 0);
            exp_cause = cause;
        end else begin
            oh = 2'(1 << reg_i);
            for (int k = 0; k <= waitn; k++) begin
                @(posedge clk); #1;
                if (k == waitn && !no_ack) bus_ack = oh;
                else bus_ack = ($urandom_range(0, 1) != 0) ? ~oh : 2'b00;
                @(negedge clk);
                check("stb_acc", bus_stb, 1);
                check("stall_acc", stall, 1);
                check("sel_acc", bus_sel, oh);
                check("we_acc", bus_we, is_st);
                check("addr_acc", bus_addr, {a[31:2], 2'b00});
                check("rvalid_acc", rdata_valid, 0);
                check("fault_acc", fault, 0);
                if (is_st) begin
                    check("be_acc", bus_be, be);
                    check("wdata_acc", bus_wdata, lanes);
                end
            end
            @(posedge clk); #1;
            bus_ack = no_ack ? oh : 2'b00;
            @(negedge clk);
            check("stall_done", stall, 0);
            check("stb_done", bus_stb, 0);
            if (no_ack) begin
                check("fault_tmo", fault, 1);
                check("rvalid_tmo", rdata_valid, 0);
                exp_cause = 2'b11;
            end else begin
                check("fault_done", fault, 0);
                check("rvalid_done", rdata_valid, !is_st);
                if (!is_st) exp_rdata = ld;
            end
        end
        check("rdata_hold", rdata, exp_rdata);
        check("cause_hold", fault_cause, exp_cause);
    endtask

    task automatic idle_cycle(input logic rv, input logic [6:0] op);
        @(posedge clk); #1;
        req_valid = rv;
        opcode_in = op;
        bus_ack   = 2'($urandom);
        @(negedge clk);
        check("stall_idle", stall, 0);
        check("stb_idle", bus_stb, 0);
        check("rvalid_idle", rdata_valid, 0);
        check("fault_idle", fault, 0);
        check("rdata_idle", rdata, exp_rdata);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_stb"}, bus_stb, 0);
        check({tag, "_sel"}, bus_sel, 0);
        check({tag, "_we"}, bus_we, 0);
        check({tag, "_be"}, bus_be, 0);
        check({tag, "_addr"}, bus_addr, 0);
        check({tag, "_wdata"}, bus_wdata, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_rvalid"}, rdata_valid, 0);
        check({tag, "_fault"}, fault, 0);
        check({tag, "_cause"}, fault_cause, 0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [3:0]  tag;
        logic        st;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        access(1'b1, SW, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
        access(1'b0, LB, 32'h1000_0003, 32'h0, 32'h80FF_FFFF, 3, 1'b0);
        check("lb_dir", rdata, 32'hFFFF_FF80);
        access(1'b0, LBU, 32'h1000_0003, 32'h0, 32'h80FF_FFFF, 3, 1'b0);
        check("lbu_dir", rdata, 32'h0000_0080);
        access(1'b1, SH, 32'h2000_0002, 32'h0000_1234, 32'h0, 1, 1'b0);
        access(1'b0, LW, 32'h1000_0002, 32'h0, 32'h0, 0, 1'b0);
        check("lw_mis_dir", fault_cause, 2'b01);
        access(1'b0, LW, 32'h7000_0000, 32'h0, 32'h0, 0, 1'b0);
        check("lw_unm_dir", fault_cause, 2'b10);
        idle_cycle(1'b0, OP_L);

`ifdef LSU_TIMEOUT_EN
        access(1'b0, LW, 32'h1000_0010, 32'h0, 32'h1111_1111, TMO - 1, 1'b1);
        check("tmo_dir", fault_cause, 2'b11);
        idle_cycle(1'b0, OP_L);
`else
        access(1'b0, LW, 32'h1000_0010, 32'h0, 32'h1111_1111, 10, 1'b0);
        check("long_wait_dir", rdata, 32'h1111_1111);
`endif

        // Reset during the second ACCESS cycle, then a late ack.
        @(posedge clk); #1;
        req_valid = 1'b1; opcode_in = OP_L; funct3 = LW; addr = 32'h1000_0020;
        bus_ack = '0; bus_rdata = {$urandom, 32'hCAFE_F00D};
        @(negedge clk);
        check("rst_req_stall", stall, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_acc1_stb", bus_stb, 1);
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        check("rst_acc2_stb", bus_stb, 1);
        @(posedge clk); #1;
        rst = 1'b0; bus_ack = 2'b01;
        @(negedge clk);
        check_all_zero("midrst");
        exp_rdata = '0;
        exp_cause = '0;
        idle_cycle(1'b0, OP_L);
        access(1'b0, LW, 32'h1000_0020, 32'h0, 32'h0BAD_C0DE, 0, 1'b0);

        // Random traffic, back-to-back with occasional idle or non-memory cycles.
        for (int n = 0; n < 40; n++) begin
            st = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       tag = 4'h7;
                1, 2:    tag = 4'h1;
                default: tag = 4'h2;
            endcase
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
            else case ($urandom_range(0, 4))
                0:       f3 = LB;
                1:       f3 = LH;
                2:       f3 = LW;
                3:       f3 = st ? LW : LBU;
                default: f3 = st ? LH : LHU;
            endcase
            access(st, f3, {tag, 28'($urandom)}, $urandom, $urandom,
                   int'($urandom_range(0, 3)), 1'b0);
            if ($urandom_range(0, 3) == 0) idle_cycle(1'b1, 7'b0110011);
        end
        idle_cycle(1'b0, OP_S);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
